// File: rtl/pmem_line_responder.sv
// Line-granular memory responder for L1 integration: answers pmem_read/pmem_write
// after a fixed latency with a one-cycle pmem_resp pulse and counts completed transactions.
module pmem_line_responder #(
  parameter int LATENCY    = 10,
  parameter int INDEX_BITS = 5,
  parameter int LINE_WIDTH = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pmem_read,
  input  logic                  pmem_write,
  input  logic [31:0]           pmem_address,
  input  logic [LINE_WIDTH-1:0] pmem_wdata,
  output logic [LINE_WIDTH-1:0] pmem_rdata,
  output logic                  pmem_resp,
  input  logic                  read_clear,
  input  logic                  write_clear,
  output logic [31:0]           read_count,
  output logic [31:0]           write_count,
  output logic                  protocol_err
);

  localparam int LINES = 2 ** INDEX_BITS;
  localparam logic [7:0] LOAD = 8'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t                  state, state_nxt;
  logic [7:0]              cnt;
  logic                    op_write;
  logic [INDEX_BITS-1:0]   idx;
  logic [LINE_WIDTH-1:0]   wdata_q;
  logic [LINE_WIDTH-1:0]   mem [LINES];
  logic [LINES-1:0]        valid;
  logic [LINE_WIDTH-1:0]   line;
  logic [LINE_WIDTH-1:0]   rdata_hold;
  logic                    accept;
  logic                    read_done;
  logic                    write_done;
  logic                    unused_addr;

  assign unused_addr = ^{pmem_address[31:5+INDEX_BITS], pmem_address[4:0]};

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (pmem_read || pmem_write) state_nxt = (LATENCY == 1) ? RESP : BUSY;
      BUSY: if (cnt == 8'd1) state_nxt = RESP;
      RESP: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    accept     = (state == IDLE) && (pmem_read || pmem_write);
    pmem_resp  = (state == RESP);
    read_done  = (state == RESP) && !op_write;
    write_done = (state == RESP) && op_write;
    line       = valid[idx] ? mem[idx] : '0;
    pmem_rdata = read_done ? line : rdata_hold;
  end

  // Transaction latch; a simultaneous read+write is taken as a write.
  always_ff @(posedge clk) begin
    if (accept) begin
      cnt      <= LOAD;
      op_write <= pmem_write;
      idx      <= pmem_address[5 +: INDEX_BITS];
      wdata_q  <= pmem_wdata;
    end else if (state == BUSY) begin
      cnt <= cnt - 8'd1;
    end
  end

  // Storage is never cleared; a reset during RESP must not commit the pending write.
  always_ff @(posedge clk) begin
    if (rst_n && write_done) mem[idx] <= wdata_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid        <= '0;
      rdata_hold   <= '0;
      read_count   <= '0;
      write_count  <= '0;
      protocol_err <= 1'b0;
    end else begin
      if (write_done) valid[idx] <= 1'b1;
      if (read_done) rdata_hold <= line;
      if (read_clear)     read_count <= '0;
      else if (read_done) read_count <= read_count + 32'd1;
      if (write_clear)     write_count <= '0;
      else if (write_done) write_count <= write_count + 32'd1;
      if (accept && pmem_read && pmem_write) protocol_err <= 1'b1;
    end
  end

endmodule
